// File: rtl/serial_sub_pkg.sv
`default_nettype none
// ============================================================================
// Module   : serial_sub_pkg
// Purpose  : Shared constants for the bit-serial subtractor controller.
//            Holds the FSM state encoding and the default operand width.
// Revision : 1.0 - initial release
// ============================================================================
package serial_sub_pkg;

  // Width of the encoded controller state
  localparam int STATE_W = 2;

  // Controller state encoding (legacy-compatible constants)
  localparam logic [STATE_W-1:0] ST_IDLE = 2'd0;
  localparam logic [STATE_W-1:0] ST_RUN  = 2'd1;
  localparam logic [STATE_W-1:0] ST_DONE = 2'd2;

  // Default operand/result width
  localparam int DEFAULT_WIDTH = 8;

endpackage : serial_sub_pkg
`default_nettype wire

// File: rtl/sub_bit_cell.sv
`default_nettype none
// ============================================================================
// Module   : sub_bit_cell
// Purpose  : Combinational one-bit full subtractor (a - b - bin) built from
//            two cascaded half-subtract stages.
// Revision : 1.0 - initial release
// ============================================================================
module sub_bit_cell (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  logic w_d1;
  logic w_bo1;
  logic w_bo2;

  // First half-subtract: a - b
  assign w_d1  = a ^ b;
  assign w_bo1 = ~a & b;

  // Second half-subtract: (a - b) - bin
  assign d     = w_d1 ^ bin;
  assign w_bo2 = ~w_d1 & bin;

  // A borrow out of either stage propagates to the next bit
  assign bout  = w_bo1 | w_bo2;

endmodule : sub_bit_cell
`default_nettype wire

// File: rtl/serial_sub_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : serial_sub_ctrl
// Purpose  : Bit-serial WIDTH-bit subtractor controller. Captures a and b on
//            an accepted start, walks a one-bit subtract cell over WIDTH
//            cycles LSB first, then presents diff = a - b and the final
//            borrow with a one-cycle done pulse.
// Revision : 1.0 - initial release
// ============================================================================
module serial_sub_ctrl
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
);

  // Counter wide enough to index WIDTH-1; it never has to hold WIDTH
  // because the FSM leaves RUN on the last bit.
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] c_cnt_last = CW'(WIDTH - 1);

  logic [STATE_W-1:0] r_state;
  logic [WIDTH-1:0]   r_a_sh;
  logic [WIDTH-1:0]   r_b_sh;
  logic [WIDTH-1:0]   r_r_sh;
  logic [CW-1:0]      r_cnt;
  logic               r_borrow;
  logic [WIDTH-1:0]   r_diff;
  logic               r_borrow_out;

  logic w_accept;
  logic w_run;
  logic w_last;
  logic w_d;
  logic w_bout;

  // A request is only honoured when the datapath is free
  assign w_accept = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
  assign w_run    = (r_state == ST_RUN);
  assign w_last   = (r_cnt == c_cnt_last);

  // One-bit subtract of the current LSBs with the running borrow
  sub_bit_cell u_cell (
    .a    (r_a_sh[0]),
    .b    (r_b_sh[0]),
    .bin  (r_borrow),
    .d    (w_d),
    .bout (w_bout)
  );

  // Controller: IDLE -> RUN on start, RUN -> DONE on last bit, DONE -> RUN/IDLE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: if (start) r_state <= ST_RUN;
        ST_RUN:  if (w_last) r_state <= ST_DONE;
        ST_DONE: r_state <= start ? ST_RUN : ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Operand/result shift registers, borrow chain and bit counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a_sh   <= '0;
      r_b_sh   <= '0;
      r_r_sh   <= '0;
      r_cnt    <= '0;
      r_borrow <= 1'b0;
    end else if (w_accept) begin
      r_a_sh   <= a;
      r_b_sh   <= b;
      r_borrow <= 1'b0;
      r_cnt    <= '0;
    end else if (w_run) begin
      r_a_sh   <= {1'b0, r_a_sh[WIDTH-1:1]};
      r_b_sh   <= {1'b0, r_b_sh[WIDTH-1:1]};
      r_r_sh   <= {w_d, r_r_sh[WIDTH-1:1]};
      r_borrow <= w_bout;
      r_cnt    <= r_cnt + 1'b1;
    end
  end

  // Result registers load only on the DONE-entry edge and hold otherwise,
  // so a following RUN never disturbs the presented result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_diff       <= '0;
      r_borrow_out <= 1'b0;
    end else if (w_run && w_last) begin
      r_diff       <= {w_d, r_r_sh[WIDTH-1:1]};
      r_borrow_out <= w_bout;
    end
  end

  assign busy       = (r_state == ST_RUN);
  assign done       = (r_state == ST_DONE);
  assign diff       = r_diff;
  assign borrow_out = r_borrow_out;

endmodule : serial_sub_ctrl
`default_nettype wire
